// File: rtl/fault_event_logger.sv
// Timestamps fault_fsm state transitions into a host-drained FIFO and runs the
// clear_warning handshake on behalf of the host.
module fault_event_logger #(
  parameter int unsigned DEPTH       = 8,
  parameter int unsigned TS_W        = 16,
  parameter int unsigned CLR_PULSE   = 2,
  parameter int unsigned CLR_TIMEOUT = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [1:0]               fsm_state,
  input  logic [2:0]               fsm_fault_id,
  output logic                     evt_valid,
  input  logic                     evt_ready,
  output logic [TS_W+7:0]          evt_data,
  output logic [$clog2(DEPTH):0]   evt_count,
  output logic [7:0]               drop_cnt,
  input  logic                     clr_req,
  output logic                     clear_warning,
  output logic                     clr_busy,
  output logic                     clr_done,
  output logic                     clr_timeout
);

  localparam int unsigned AW   = $clog2(DEPTH);
  localparam int unsigned CMAX = (CLR_PULSE > CLR_TIMEOUT) ? CLR_PULSE : CLR_TIMEOUT;
  localparam int unsigned CW   = $clog2(CMAX + 1);

  typedef enum logic [1:0] {NORMAL, WARNING, FAULT, SHUTDOWN} fsm_code_t;
  typedef enum logic [1:0] {S_IDLE, S_PULSE, S_WAIT} clr_state_t;

  logic [TS_W+7:0] mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [AW:0]     count;
  logic [TS_W-1:0] ts;
  logic [1:0]      prev_state_q;
  logic            lost_pending;
  logic            push, pop, full, wr_en;

  clr_state_t      clr_state, clr_next;
  logic [CW-1:0]   clr_cnt, clr_cnt_next;

  always_comb begin
    full  = (count == (AW+1)'(DEPTH));
    push  = (fsm_state != prev_state_q);
    pop   = (count != '0) && evt_ready;
    // A full FIFO still accepts a record when the head leaves on the same edge.
    wr_en = push && (!full || pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ts           <= '0;
      prev_state_q <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      lost_pending <= 1'b0;
      drop_cnt     <= '0;
    end else begin
      ts           <= ts + 1'b1;
      prev_state_q <= fsm_state;
      if (wr_en) begin
        wr_ptr       <= wr_ptr + 1'b1;
        lost_pending <= 1'b0;
      end else if (push) begin
        lost_pending <= 1'b1;
        if (drop_cnt != '1) drop_cnt <= drop_cnt + 8'd1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{AW{1'b0}}, wr_en} - {{AW{1'b0}}, pop};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && wr_en)
      mem[wr_ptr] <= {ts, prev_state_q, fsm_state, fsm_fault_id, lost_pending};
  end

  assign evt_valid = (count != '0);
  assign evt_count = count;
  assign evt_data  = evt_valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      clr_state <= S_IDLE;
      clr_cnt   <= '0;
    end else begin
      clr_state <= clr_next;
      clr_cnt   <= clr_cnt_next;
    end
  end

  always_comb begin
    clr_next      = clr_state;
    clr_cnt_next  = clr_cnt;
    clear_warning = 1'b0;
    clr_busy      = 1'b0;
    clr_done      = 1'b0;
    clr_timeout   = 1'b0;
    case (clr_state)
      S_IDLE: begin
        clr_cnt_next = '0;
        if (clr_req) clr_next = S_PULSE;
      end
      S_PULSE: begin
        clear_warning = 1'b1;
        clr_busy      = 1'b1;
        if (clr_cnt == CW'(CLR_PULSE - 1)) begin
          clr_next     = S_WAIT;
          clr_cnt_next = '0;
        end else begin
          clr_cnt_next = clr_cnt + 1'b1;
        end
      end
      S_WAIT: begin
        clr_busy = 1'b1;
        // NORMAL is checked first so it wins over an expiring timeout.
        if (fsm_state == NORMAL) begin
          clr_done = 1'b1;
          clr_next = S_IDLE;
        end else if (clr_cnt == CW'(CLR_TIMEOUT - 1)) begin
          clr_timeout = 1'b1;
          clr_next    = S_IDLE;
        end else begin
          clr_cnt_next = clr_cnt + 1'b1;
        end
      end
      default: clr_next = S_IDLE;
    endcase
  end

endmodule
